// File: rtl/bird_pkg.sv
// Shared constants and types for the bird sprite renderer.
package bird_pkg;
  localparam int SPRITE_W = 24;
  localparam int SPRITE_H = 24;
  localparam logic [11:0] KEY_COLOR = 12'hF0F;
  localparam int RENDER_LAT = 3;
  localparam int ADDR_W = 5;

  typedef logic [11:0] rgb12_t;

  // Per-pixel sideband that travels alongside the ROM lookup.
  typedef struct packed {
    logic   video_on;
    logic   hsync;
    logic   vsync;
    rgb12_t bg_rgb;
    logic   pipe_on;
    logic   in_box;
  } side_t;
endpackage

// File: rtl/bird_sync_delay.sv
// N-stage shift register for the per-pixel sideband (sync, video_on, bg, pipe, in_box).
module bird_sync_delay
  import bird_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  side_t din,
  output side_t dout
);
  side_t [STAGES-1:0] stg_q, stg_d;

  always_comb begin
    stg_d    = stg_q;
    stg_d[0] = din;
    for (int i = 1; i < STAGES; i++) stg_d[i] = stg_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  assign dout = stg_q[STAGES-1];
endmodule

// File: rtl/bird_sprite_renderer.sv
// Bird sprite ROM consumer: address generation, colour-key compositing and sticky collision.
// Define BIRD_SCALE2X_EN to draw each ROM texel as a 2x2 screen block.
module bird_sprite_renderer #(
  parameter int          X_W       = 10,
  parameter int          Y_W       = 10,
  parameter int          SPRITE_W  = bird_pkg::SPRITE_W,
  parameter int          SPRITE_H  = bird_pkg::SPRITE_H,
  parameter logic [11:0] KEY_COLOR = bird_pkg::KEY_COLOR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start,
  input  logic [X_W-1:0] bird_x,
  input  logic [Y_W-1:0] bird_y,
  input  logic [X_W-1:0] pixel_x,
  input  logic [Y_W-1:0] pixel_y,
  input  logic           video_on,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic [11:0]    bg_rgb,
  input  logic           pipe_on,
  input  logic           collide_clr,
  output logic [4:0]     rom_row,
  output logic [4:0]     rom_col,
  input  logic [11:0]    rom_pixel,
  output logic [11:0]    rgb_out,
  output logic           video_on_out,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           bird_on,
  output logic           collide
);
  import bird_pkg::*;

`ifdef BIRD_SCALE2X_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  // Box extents held one bit wider than the scan so a bird near the edge cannot wrap.
  localparam logic [X_W:0] BOX_W = (X_W+1)'(SPRITE_W << SH);
  localparam logic [Y_W:0] BOX_H = (Y_W+1)'(SPRITE_H << SH);

  logic [X_W-1:0]    bird_x_q, bird_x_d;
  logic [Y_W-1:0]    bird_y_q, bird_y_d;
  logic [ADDR_W-1:0] rom_row_q, rom_row_d, rom_col_q, rom_col_d;
  rgb12_t            rgb_q, rgb_d;
  logic              bird_on_q, bird_on_d;
  logic              video_on_q, video_on_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              collide_q, collide_d;
  logic              in_box, opaque;
  side_t             side_in, side_d2;

  always_comb begin
    bird_x_d = frame_start ? bird_x : bird_x_q;
    bird_y_d = frame_start ? bird_y : bird_y_q;

    in_box = video_on
          && ({1'b0, pixel_x} >= {1'b0, bird_x_q})
          && ({1'b0, pixel_x} <  ({1'b0, bird_x_q} + BOX_W))
          && ({1'b0, pixel_y} >= {1'b0, bird_y_q})
          && ({1'b0, pixel_y} <  ({1'b0, bird_y_q} + BOX_H));

    rom_col_d = in_box ? ADDR_W'((pixel_x - bird_x_q) >> SH) : '0;
    rom_row_d = in_box ? ADDR_W'((pixel_y - bird_y_q) >> SH) : '0;

    side_in.video_on = video_on;
    side_in.hsync    = hsync_in;
    side_in.vsync    = vsync_in;
    side_in.bg_rgb   = bg_rgb;
    side_in.pipe_on  = pipe_on;
    side_in.in_box   = in_box;
  end

  bird_sync_delay #(.STAGES(RENDER_LAT - 1)) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (side_in),
    .dout (side_d2)
  );

  always_comb begin
    opaque     = side_d2.in_box && (rom_pixel != KEY_COLOR);
    rgb_d      = opaque ? rom_pixel : (side_d2.video_on ? side_d2.bg_rgb : 12'h000);
    bird_on_d  = opaque;
    video_on_d = side_d2.video_on;
    hsync_d    = side_d2.hsync;
    vsync_d    = side_d2.vsync;
    // A hit on the same edge as a clear keeps the flag set.
    if (opaque && side_d2.pipe_on) collide_d = 1'b1;
    else if (collide_clr)          collide_d = 1'b0;
    else                           collide_d = collide_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bird_x_q   <= '0;
      bird_y_q   <= '0;
      rom_row_q  <= '0;
      rom_col_q  <= '0;
      rgb_q      <= '0;
      bird_on_q  <= 1'b0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      bird_x_q   <= bird_x_d;
      bird_y_q   <= bird_y_d;
      rom_row_q  <= rom_row_d;
      rom_col_q  <= rom_col_d;
      rgb_q      <= rgb_d;
      bird_on_q  <= bird_on_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      collide_q  <= collide_d;
    end
  end

  assign rom_row      = rom_row_q;
  assign rom_col      = rom_col_q;
  assign rgb_out      = rgb_q;
  assign bird_on      = bird_on_q;
  assign video_on_out = video_on_q;
  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign collide      = collide_q;
endmodule
